// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// NOP word, word size and a word-alignment helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake: request/address out, ready strobe
// and read data back.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with reset value, sequential increment and a
// branch-over-jump redirect mux.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic        o_redirect,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_target;

    assign o_redirect = i_branch_taken | i_jump;
    assign w_target   = i_branch_taken ? word_align(i_branch_target)
                                       : word_align(i_jump_target);

    // 32-bit modulo add: the top word wraps to address zero
    assign o_pc_plus4 = r_pc + WORD_BYTES;
    assign o_pc       = r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= word_align(RESET_PC);
        end else if (o_redirect) begin
            r_pc <= w_target;
        end else if (i_inc) begin
            r_pc <= o_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, imem handshake, one-entry
// pending buffer for stalled returns, and registered IF/ID outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    fetch_unit_if.master      imem,
    output logic [31:0]       pc_4,
    output logic [31:0]       instruction,
    output logic              if_id_enable
);

    fetch_state_t r_state, w_state_next;

    logic        r_squash,    w_squash_next;
    logic [31:0] r_old_addr,  w_old_addr_next;
    logic        r_buf_valid, w_buf_valid_next;
    logic [31:0] r_buf_pc4,   w_buf_pc4_next;
    logic [31:0] r_buf_instr, w_buf_instr_next;
    logic [31:0] r_pc4,       w_pc4_next;
    logic [31:0] r_instr,     w_instr_next;
    logic        r_bubble,    w_bubble_next;

    logic        w_inc;
    logic        w_redirect;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_inc           (w_inc),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .o_redirect      (w_redirect),
        .o_pc            (w_pc),
        .o_pc_plus4      (w_pc_plus4)
    );

    // A squashed request keeps its original address on the bus until
    // memory answers it; the new PC is issued the cycle after.
    assign imem.req     = (r_state == FETCH);
    assign imem.addr    = r_squash ? r_old_addr : w_pc;
    assign pc_4         = r_pc4;
    assign instruction  = r_instr;
    assign if_id_enable = r_bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_squash_next    = r_squash;
        w_old_addr_next  = r_old_addr;
        w_buf_valid_next = r_buf_valid;
        w_buf_pc4_next   = r_buf_pc4;
        w_buf_instr_next = r_buf_instr;
        w_pc4_next       = r_pc4;
        w_instr_next     = r_instr;
        w_bubble_next    = r_bubble;
        w_inc            = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (imem.ready) begin
                    if (r_squash) begin
                        w_squash_next = 1'b0;
                        if (!stall) begin
                            w_bubble_next = 1'b1;
                        end
                    end else if (!stall) begin
                        w_pc4_next    = w_pc_plus4;
                        w_instr_next  = imem.rdata;
                        w_bubble_next = 1'b0;
                        w_inc         = 1'b1;
                    end else begin
                        w_buf_valid_next = 1'b1;
                        w_buf_pc4_next   = w_pc_plus4;
                        w_buf_instr_next = imem.rdata;
                        w_inc            = 1'b1;
                        w_state_next     = HOLD;
                    end
                end else if (!stall) begin
                    w_bubble_next = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    if (r_buf_valid) begin
                        w_pc4_next    = r_buf_pc4;
                        w_instr_next  = r_buf_instr;
                        w_bubble_next = 1'b0;
                    end
                    w_buf_valid_next = 1'b0;
                    w_state_next     = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Redirect overrides stall and any return arriving this cycle
        if (w_redirect) begin
            w_state_next     = FETCH;
            w_buf_valid_next = 1'b0;
            w_bubble_next    = 1'b1;
            w_inc            = 1'b0;
            w_squash_next    = (r_state == FETCH) && !imem.ready;
            w_old_addr_next  = r_squash ? r_old_addr : w_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_squash    <= 1'b0;
            r_old_addr  <= 32'h0000_0000;
            r_buf_valid <= 1'b0;
            r_buf_pc4   <= 32'h0000_0000;
            r_buf_instr <= NOP_WORD;
            r_pc4       <= 32'h0000_0000;
            r_instr     <= NOP_WORD;
            r_bubble    <= 1'b1;
        end else begin
            r_squash    <= w_squash_next;
            r_old_addr  <= w_old_addr_next;
            r_buf_valid <= w_buf_valid_next;
            r_buf_pc4   <= w_buf_pc4_next;
            r_buf_instr <= w_buf_instr_next;
            r_pc4       <= w_pc4_next;
            r_instr     <= w_instr_next;
            r_bubble    <= w_bubble_next;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID register. It owns the program counter and issues word reads to instruction memory over a request/ready handshake. It presents each fetched instruction with its PC+4 to IF/ID, and applies hazard-unit stalls and branch/jump redirects resolved in ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and outputs this cycle.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_target  in  32  branch destination.
- jump  in  1  ID-stage jump.
- jump_target  in  32  jump destination.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of request; bits [1:0] always 0.
- imem_ready  in  1  single-cycle strobe: request accepted, imem_rdata valid.
- imem_rdata  in  32  instruction word.
- pc_4  out  32  PC+4 of presented instruction; drives IF/ID PC_4.
- instruction  out  32  presented instruction; drives IF/ID Instrucction.
- if_id_enable  out  1  drives IF/ID IF_ID_enable: 0 = valid instruction to latch, 1 = bubble.

## Operation
- State register has three states: IDLE, FETCH, HOLD.
- Reset (rst_n=0 at posedge): pc=RESET_PC, state=IDLE, imem_req=0, pc_4=0, instruction=0, if_id_enable=1, pending buffer empty, squash=0.
- IDLE: next state FETCH unconditionally.
- FETCH: imem_req=1 and imem_addr=pc. Address is held stable until imem_ready.
  - imem_ready and stall=0: pc_4 and instruction load pc+4 and imem_rdata, if_id_enable=0, pc<=pc+4, state stays FETCH.
  - imem_ready and stall=1: word and pc+4 go into the one-entry pending buffer, pc<=pc+4, state goes to HOLD. Outputs are unchanged.
  - No imem_ready and stall=0: if_id_enable=1 (bubble).
  - No imem_ready and stall=1: outputs hold.
- HOLD: imem_req=0. While stall=1 everything holds. When stall=0, the pending buffer moves to the outputs, if_id_enable=0, the buffer empties, and state goes to FETCH.
- Redirect target select: branch_taken has priority over jump. Target bits [1:0] are forced to 0.
- Redirect behaviour (either input high at a posedge):
  - pc loads the target, pending buffer is dropped, and the output goes to bubble (if_id_enable=1).
  - Next state is FETCH. There is no delay slot: the instruction being fetched is squashed.
- Redirect while a FETCH request is outstanding without ready: squash=1. The next imem_ready is discarded (no output, pc not incremented), squash clears, and the request is reissued at the new pc in the following cycle.
- Redirect in the same cycle as imem_ready: the returned word is discarded and squash stays 0.
- Redirect and stall together: redirect wins.
- Address arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0. No overflow flag.

## Timing
- All outputs are registered on posedge clk. IF/ID samples on negedge, giving a half-cycle setup margin.
- First imem_req: cycle after the first posedge with rst_n=1 (the IDLE cycle).
- Latency: imem_ready at edge N puts the instruction on the outputs immediately after edge N (stall=0).
- With zero-wait memory (imem_ready tied 1), throughput is one instruction per cycle.
- Redirect at edge N: imem_addr=target after edge N, with the first target instruction valid one edge after its ready. Outstanding-squash case costs one extra request cycle.
- Stall release from HOLD: the buffered instruction appears after the release edge, and imem_req reasserts in that same cycle.
- rst_n low mid-request: state returns to reset values at that edge. A late imem_ready for the old request is ignored while in IDLE.

## Structure
- Shared pipeline package holds:
  - state encoding IDLE=2'd0, FETCH=2'd1, HOLD=2'd2;
  - the NOP word 32'h0000_0000;
  - the word size constant 32'd4.
- One sub-module is natural: fetch_pc_reg, which holds the PC register with reset, increment and redirect-mux logic.
- The FSM, pending buffer and output registers live in fetch_unit.

## Test plan
- Reset and stream: RESET_PC=0, imem_ready=1, imem_rdata=addr+32'h1000. After reset, imem_addr goes 0,4,8 on successive cycles. Outputs give pc_4=4/instruction=32'h1000, then 8/32'h1004, with if_id_enable=0.
- Wait states: ready every third cycle. imem_addr holds each address for 3 cycles, and if_id_enable=1 for the two intermediate cycles.
- Stall with capture: stall=1 in the cycle ready returns word at addr 8. State goes to HOLD, imem_req=0, outputs still show pc_4=8. After stall drops: pc_4=12, then imem_addr=12.
- Branch during wait: request at 0x10 outstanding, branch_taken=1 with target 0x40. Late ready for 0x10 is discarded, next imem_addr=0x40, first valid pc_4=0x44.
- Priority and alignment: branch_taken=1 (target 0x80) and jump=1 (target 0x200) together, plus stall=1. Next imem_addr=0x80 and output is bubble. Jump target 0x203 fetches 0x200.
- Wrap and reset: pc=0xFFFF_FFFC gives pc_4=0 and next imem_addr=0. rst_n low during an outstanding request returns all outputs to reset values, with imem_addr=RESET_PC on the first FETCH.
